// File: rtl/conv3_pkg.sv
// ---------------------------------------------------------------------------
// conv3_pkg : shared widths and window state type for the 3-tap conv engine
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package conv3_pkg;

  localparam int DATA_W   = 4;
  localparam int KERNEL_W = 4;
  localparam int RESULT_W = 10;
  localparam int TAPS     = 3;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FILL1  = 2'd1,
    FILL2  = 2'd2,
    STREAM = 2'd3
  } win_state_e;

endpackage

`default_nettype wire

// File: rtl/conv3_engine_if.sv
// ---------------------------------------------------------------------------
// conv3_engine_if : kernel/sample/result bundle between driver and engine
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface conv3_engine_if;
  import conv3_pkg::*;

  logic [KERNEL_W-1:0] kernel_0;
  logic [KERNEL_W-1:0] kernel_1;
  logic [KERNEL_W-1:0] kernel_2;
  logic                kernel_load;
  logic [DATA_W-1:0]   data;
  logic                data_valid;
  logic [RESULT_W-1:0] result;
  logic                result_valid;

  modport master (
    output kernel_0, kernel_1, kernel_2, kernel_load, data, data_valid,
    input  result, result_valid
  );

  modport slave (
    input  kernel_0, kernel_1, kernel_2, kernel_load, data, data_valid,
    output result, result_valid
  );

endinterface

`default_nettype wire

// File: rtl/conv3_window.sv
// ---------------------------------------------------------------------------
// conv3_window : 3-deep sample shift register with fill-tracking FSM
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module conv3_window
  import conv3_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              sample_valid_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic [DATA_W-1:0] x0_o,
  output logic [DATA_W-1:0] x1_o,
  output logic [DATA_W-1:0] x2_o,
  output logic              window_full_o
);

  win_state_e        state_q, state_d;
  logic [DATA_W-1:0] win_q [TAPS];
  logic [DATA_W-1:0] win_d [TAPS];
  logic              full_q, full_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      full_q  <= 1'b0;
      for (int i = 0; i < TAPS; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      for (int i = 0; i < TAPS; i++) win_q[i] <= win_d[i];
    end
  end

  // A clear coinciding with a sample restarts the window with that sample.
  always_comb begin
    state_d = state_q;
    full_d  = 1'b0;
    win_d   = win_q;
    if (sample_valid_i) begin
      win_d[0] = sample_i;
      for (int i = 1; i < TAPS; i++) win_d[i] = win_q[i-1];
    end
    if (clear_i) begin
      state_d = sample_valid_i ? FILL1 : EMPTY;
    end else if (sample_valid_i) begin
      full_d = (state_q == FILL2) || (state_q == STREAM);
      case (state_q)
        EMPTY:   state_d = FILL1;
        FILL1:   state_d = FILL2;
        default: state_d = STREAM;
      endcase
    end
  end

  assign x0_o          = win_q[0];
  assign x1_o          = win_q[1];
  assign x2_o          = win_q[2];
  assign window_full_o = full_q;

endmodule

`default_nettype wire

// File: rtl/conv3_engine.sv
// ---------------------------------------------------------------------------
// conv3_engine : streaming 3-tap unsigned convolution, 2-stage MAC pipeline
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module conv3_engine
  import conv3_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  conv3_engine_if.slave  bus
);

  localparam int PROD_W = DATA_W + KERNEL_W;

  logic [DATA_W-1:0]   x0, x1, x2;
  logic [DATA_W-1:0]   win_x [TAPS];
  logic                window_full;

  logic [KERNEL_W-1:0] kernel_q [TAPS];
  logic [KERNEL_W-1:0] kernel_d [TAPS];
  logic [PROD_W-1:0]   prod_q   [TAPS];
  logic [PROD_W-1:0]   prod_d   [TAPS];
  logic                s1_valid_q, s1_valid_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic                result_valid_q, result_valid_d;
  logic [RESULT_W-1:0] sum;

  conv3_window u_window (
    .clk            (clk),
    .rst            (rst),
    .clear_i        (bus.kernel_load),
    .sample_valid_i (bus.data_valid),
    .sample_i       (bus.data),
    .x0_o           (x0),
    .x1_o           (x1),
    .x2_o           (x2),
    .window_full_o  (window_full)
  );

  assign win_x[0] = x0;
  assign win_x[1] = x1;
  assign win_x[2] = x2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        kernel_q[i] <= '0;
        prod_q[i]   <= '0;
      end
      s1_valid_q     <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      kernel_q       <= kernel_d;
      prod_q         <= prod_d;
      s1_valid_q     <= s1_valid_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  // A kernel load kills every in-flight stage so no result mixes kernels or windows.
  always_comb begin
    kernel_d = kernel_q;
    if (bus.kernel_load) begin
      kernel_d[0] = bus.kernel_0;
      kernel_d[1] = bus.kernel_1;
      kernel_d[2] = bus.kernel_2;
    end
    for (int i = 0; i < TAPS; i++) begin
      prod_d[i] = PROD_W'(win_x[i]) * PROD_W'(kernel_q[i]);
    end
    s1_valid_d = window_full && !bus.kernel_load;
    sum = '0;
    for (int i = 0; i < TAPS; i++) begin
      sum = sum + RESULT_W'(prod_q[i]);
    end
    result_valid_d = s1_valid_q && !bus.kernel_load;
    result_d       = result_valid_d ? sum : result_q;
  end

  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_conv3_engine.sv
// ---------------------------------------------------------------------------
// tb_conv3_engine : directed vector table, corner sequences and random stream
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_conv3_engine;
  import conv3_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv3_engine_if bus ();

  conv3_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit kl; int k0; int k1; int k2; bit dv; int d; int ev; int er;
  } vec_t;
  typedef struct { int due; int val; } pend_t;

  vec_t  tbl [$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: list of accepted samples since the last kernel load and
  // a queue of results scheduled two edges after their accepting edge.
  int    m_win [$];
  int    m_k [3];
  pend_t m_pend [$];
  int    m_edge;
  int    m_ev;
  int    m_er;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_win.delete();
    m_pend.delete();
    for (int i = 0; i < 3; i++) m_k[i] = 0;
    m_edge = 0;
    m_ev   = 0;
    m_er   = 0;
  endtask

  task automatic model_edge(input bit kl, input int k0, input int k1, input int k2,
                            input bit dv, input int d);
    pend_t p;
    m_edge++;
    if (kl) begin
      m_pend.delete();
      m_win.delete();
      m_k[0] = k0; m_k[1] = k1; m_k[2] = k2;
    end
    m_ev = 0;
    if (m_pend.size() > 0 && m_pend[0].due == m_edge) begin
      m_ev = 1;
      m_er = m_pend[0].val;
      void'(m_pend.pop_front());
    end
    if (dv) begin
      m_win.push_front(d);
      if (m_win.size() > 3) void'(m_win.pop_back());
      if (m_win.size() == 3) begin
        p.due = m_edge + 2;
        p.val = m_k[0] * m_win[0] + m_k[1] * m_win[1] + m_k[2] * m_win[2];
        m_pend.push_back(p);
      end
    end
  endtask

  task automatic step(input bit kl, input int k0, input int k1, input int k2,
                      input bit dv, input int d);
    bus.kernel_load = kl;
    bus.kernel_0    = KERNEL_W'(k0);
    bus.kernel_1    = KERNEL_W'(k1);
    bus.kernel_2    = KERNEL_W'(k2);
    bus.data_valid  = dv;
    bus.data        = DATA_W'(d);
    @(posedge clk);
    model_edge(kl, k0, k1, k2, dv, d);
    @(negedge clk);
    chk("model_valid", int'(bus.result_valid), m_ev);
    chk("model_result", int'(bus.result), m_er);
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 0, 1'b0, 0);
  endtask

  task automatic addv(input bit kl, input int k0, input int k1, input int k2,
                      input bit dv, input int d, input int ev, input int er);
    vec_t v;
    v.kl = kl; v.k0 = k0; v.k1 = k1; v.k2 = k2;
    v.dv = dv; v.d = d; v.ev = ev; v.er = er;
    tbl.push_back(v);
  endtask

  initial begin
    int gexp [4];
    bit kl;
    bit dv;

    // kl k0 k1 k2 dv d | expected valid, result after the edge
    addv(1, 1, 1, 1, 0, 0,  0, 0);
    addv(0, 0, 0, 0, 1, 1,  0, 0);
    addv(0, 0, 0, 0, 1, 2,  0, 0);
    addv(0, 0, 0, 0, 1, 3,  0, 0);
    addv(0, 0, 0, 0, 1, 4,  0, 0);
    addv(0, 0, 0, 0, 0, 0,  1, 6);
    addv(0, 0, 0, 0, 0, 0,  1, 9);
    addv(0, 0, 0, 0, 0, 0,  0, 9);
    addv(1, 1, 2, 3, 0, 0,  0, 9);
    addv(0, 0, 0, 0, 1, 1,  0, 9);
    addv(0, 0, 0, 0, 1, 2,  0, 9);
    addv(0, 0, 0, 0, 1, 3,  0, 9);
    addv(0, 0, 0, 0, 0, 0,  0, 9);
    addv(0, 0, 0, 0, 0, 0,  1, 10);
    addv(0, 0, 0, 0, 0, 0,  0, 10);
    addv(1, 15, 15, 15, 1, 15, 0, 10);
    addv(0, 0, 0, 0, 1, 15, 0, 10);
    addv(0, 0, 0, 0, 1, 15, 0, 10);
    addv(0, 0, 0, 0, 0, 0,  0, 10);
    addv(0, 0, 0, 0, 0, 0,  1, 675);
    addv(0, 0, 0, 0, 0, 0,  0, 675);
    addv(1, 1, 1, 1, 0, 0,  0, 675);
    addv(0, 0, 0, 0, 1, 5,  0, 675);
    addv(0, 0, 0, 0, 1, 5,  0, 675);
    addv(0, 0, 0, 0, 1, 5,  0, 675);
    addv(1, 2, 0, 0, 0, 0,  0, 675);
    addv(0, 0, 0, 0, 1, 7,  0, 675);
    addv(0, 0, 0, 0, 1, 1,  0, 675);
    addv(0, 0, 0, 0, 1, 3,  0, 675);
    addv(0, 0, 0, 0, 0, 0,  0, 675);
    addv(0, 0, 0, 0, 0, 0,  1, 6);
    addv(0, 0, 0, 0, 0, 0,  0, 6);
    addv(1, 1, 1, 1, 0, 0,  0, 6);
    addv(0, 0, 0, 0, 1, 1,  0, 6);
    addv(0, 0, 0, 0, 1, 1,  0, 6);
    addv(0, 0, 0, 0, 1, 1,  0, 6);
    addv(0, 0, 0, 0, 0, 0,  0, 6);
    addv(1, 0, 0, 0, 0, 0,  0, 6);
    addv(0, 0, 0, 0, 0, 0,  0, 6);

    rst             = 1'b1;
    bus.kernel_load = 1'b0;
    bus.kernel_0    = '0;
    bus.kernel_1    = '0;
    bus.kernel_2    = '0;
    bus.data_valid  = 1'b0;
    bus.data        = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_valid", int'(bus.result_valid), 0);
    chk("reset_result", int'(bus.result), 0);

    foreach (tbl[i]) begin
      step(tbl[i].kl, tbl[i].k0, tbl[i].k1, tbl[i].k2, tbl[i].dv, tbl[i].d);
      chk($sformatf("vec%0d_valid", i), int'(bus.result_valid), tbl[i].ev);
      chk($sformatf("vec%0d_result", i), int'(bus.result), tbl[i].er);
    end

    // Gapped stream: each result lands exactly two edges after its sample.
    gexp = '{0, 0, 10, 16};
    step(1'b1, 1, 2, 3, 1'b0, 0);
    for (int s = 0; s < 4; s++) begin
      step(1'b0, 0, 0, 0, 1'b1, s + 1);
      chk("gap_e0_valid", int'(bus.result_valid), 0);
      idle();
      chk("gap_e1_valid", int'(bus.result_valid), 0);
      idle();
      chk("gap_e2_valid", int'(bus.result_valid), (gexp[s] != 0) ? 1 : 0);
      if (gexp[s] != 0) chk("gap_e2_result", int'(bus.result), gexp[s]);
    end

    // Asynchronous reset while a result is on the outputs.
    step(1'b1, 1, 1, 1, 1'b0, 0);
    step(1'b0, 0, 0, 0, 1'b1, 2);
    step(1'b0, 0, 0, 0, 1'b1, 2);
    step(1'b0, 0, 0, 0, 1'b1, 2);
    idle();
    idle();
    chk("pre_rst_valid", int'(bus.result_valid), 1);
    chk("pre_rst_result", int'(bus.result), 6);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", int'(bus.result_valid), 0);
    chk("async_rst_result", int'(bus.result), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) step(1'b0, 0, 0, 0, 1'b1, 4);
    idle();
    idle();
    chk("post_rst_valid", int'(bus.result_valid), 1);
    chk("post_rst_result", int'(bus.result), 0);

    for (int n = 0; n < 600; n++) begin
      kl = ($urandom_range(15) == 0);
      dv = ($urandom_range(3) != 0);
      step(kl, int'($urandom_range(15)), int'($urandom_range(15)),
           int'($urandom_range(15)), dv, int'($urandom_range(15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
